// File: rtl/regfile_pkg.sv
// Shared widths and arbiter state encoding for the register-file writeback arbiter.
package regfile_pkg;
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam int BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } arb_state_e;
endpackage

// File: rtl/regfile_wb_arbiter_sat_counter.sv
// Saturating event counter: stops at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ALU/MEM) for the register file write port, with forced
// read gaps after MAX_BURST writes. Define REGFILE_ARB_BYPASS_EN to enable read bypass outputs.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_addr,
    input  logic [REG_DW-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_addr,
    input  logic [REG_DW-1:0] mem_data,
    output logic              mem_ready,
    output logic              Write_Reg,
    output logic [REG_AW-1:0] W_Addr,
    output logic [REG_DW-1:0] W_Data,
    input  logic [REG_AW-1:0] R_Addr_A,
    input  logic [REG_AW-1:0] R_Addr_B,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic [REG_DW-1:0] fwd_data_a,
    output logic [REG_DW-1:0] fwd_data_b,
    output logic [CNT_W-1:0]  collide_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [1:0]        dbg_state
);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    arb_state_e         state_q, state_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               write_reg_q, write_reg_d;
    logic [REG_AW-1:0]  w_addr_q, w_addr_d;
    logic [REG_DW-1:0]  w_data_q, w_data_d;

    logic              in_arb, both, collide;
    logic              grant_alu, grant_mem, any_grant;
    logic [REG_AW-1:0] win_addr;
    logic [REG_DW-1:0] win_data;
    logic              collide_inc, drop_inc;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            rr_ptr_q    <= 1'b0;
            write_reg_q <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            write_reg_q <= write_reg_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
        end
    end

    // A grant taken in IDLE counts as the first beat of the burst.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE, WRITE: begin
                if (any_grant) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d     = GAP;
                        burst_cnt_d = '0;
                    end else begin
                        state_d     = WRITE;
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            end
            GAP: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // On an address collision the younger load wins and the ALU result is dropped.
    always_comb begin
        in_arb    = !Reset && (state_q != GAP);
        both      = alu_valid && mem_valid;
        collide   = both && (alu_addr == mem_addr);
        grant_mem = in_arb && mem_valid && (!alu_valid || collide || rr_ptr_q);
        grant_alu = in_arb && alu_valid && (!mem_valid || collide || !rr_ptr_q);
        any_grant = grant_alu || grant_mem;
        win_addr  = grant_mem ? mem_addr : alu_addr;
        win_data  = grant_mem ? mem_data : alu_data;

        rr_ptr_d    = rr_ptr_q ^ (in_arb && both && !collide);
        write_reg_d = any_grant && (win_addr != REG_ZERO);
        w_addr_d    = write_reg_d ? win_addr : w_addr_q;
        w_data_d    = write_reg_d ? win_data : w_data_q;
        collide_inc = in_arb && collide;
        drop_inc    = any_grant && (win_addr == REG_ZERO);
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;
    assign Write_Reg = write_reg_q;
    assign W_Addr    = w_addr_q;
    assign W_Data    = w_data_q;
    assign dbg_state = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_collide_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (collide_inc),
        .clear (1'b0),
        .count (collide_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (drop_inc),
        .clear (1'b0),
        .count (drop_cnt)
    );

`ifdef REGFILE_ARB_BYPASS_EN
    always_comb begin
        fwd_hit_a  = write_reg_q && (w_addr_q != REG_ZERO) && (R_Addr_A == w_addr_q);
        fwd_hit_b  = write_reg_q && (w_addr_q != REG_ZERO) && (R_Addr_B == w_addr_q);
        fwd_data_a = fwd_hit_a ? w_data_q : '0;
        fwd_data_b = fwd_hit_b ? w_data_q : '0;
    end
`else
    logic unused_raddr;
    assign unused_raddr = ^{R_Addr_A, R_Addr_B};
    assign fwd_hit_a  = 1'b0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_a = '0;
    assign fwd_data_b = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter (MAX_BURST=4, CNT_W=16).
module tb_regfile_wb_arbiter;
    localparam int CNT_W = 16;
    localparam logic [31:0] ALU_D = 32'h0000_AAAA;
    localparam logic [31:0] MEM_D = 32'h0000_BBBB;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        Write_Reg;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic [4:0]  R_Addr_A, R_Addr_B;
    logic        fwd_hit_a, fwd_hit_b;
    logic [31:0] fwd_data_a, fwd_data_b;
    logic [CNT_W-1:0] collide_cnt, drop_cnt;
    logic [1:0]  dbg_state;

    logic [37:0] exp_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 Clk = ~Clk;

    regfile_wb_arbiter #(.MAX_BURST(4), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .collide_cnt(collide_cnt), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [37:0] wr(input logic we, input logic [4:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    task automatic check_out();
        logic [37:0] e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("Write_Reg", {31'd0, Write_Reg}, {31'd0, e[37]});
            if (e[37]) begin
                chk("W_Addr", {27'd0, W_Addr}, {27'd0, e[36:32]});
                chk("W_Data", W_Data, e[31:0]);
            end
        end
    endtask

    // Called at posedge+1; drives one cycle of requests and checks the following cycle.
    task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic er_a, input logic er_m, input logic [37:0] e);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        #1;
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, er_a});
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, er_m});
        exp_q.push_back(e);
        @(posedge Clk); #1;
        check_out();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, wr(1'b0, 5'd0, 32'd0));
    endtask

    // Four contended grants starting from ALU, then the forced gap.
    task automatic burst_alu_first();
        cycle(1'b1, 5'd5, ALU_D, 1'b1, 5'd6, MEM_D, 1'b1, 1'b0, wr(1'b1, 5'd5, ALU_D));
        cycle(1'b1, 5'd5, ALU_D, 1'b1, 5'd6, MEM_D, 1'b0, 1'b1, wr(1'b1, 5'd6, MEM_D));
        cycle(1'b1, 5'd5, ALU_D, 1'b1, 5'd6, MEM_D, 1'b1, 1'b0, wr(1'b1, 5'd5, ALU_D));
        cycle(1'b1, 5'd5, ALU_D, 1'b1, 5'd6, MEM_D, 1'b0, 1'b1, wr(1'b1, 5'd6, MEM_D));
        chk("state_gap", {30'd0, dbg_state}, 32'd2);
        cycle(1'b1, 5'd5, ALU_D, 1'b1, 5'd6, MEM_D, 1'b0, 1'b0, wr(1'b0, 5'd0, 32'd0));
    endtask

    initial begin
        Reset = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1234;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h5678;
        R_Addr_A = 5'd0; R_Addr_B = 5'd0;

        repeat (2) @(posedge Clk);
        #1;
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_Write_Reg", {31'd0, Write_Reg}, 32'd0);
        chk("rst_W_Addr", {27'd0, W_Addr}, 32'd0);
        chk("rst_W_Data", W_Data, 32'd0);
        chk("rst_collide", {16'd0, collide_cnt}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        Reset = 1'b0;
        @(posedge Clk); #1;

        // single ALU write
        cycle(1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, wr(1'b1, 5'd3, 32'h1234));
        idle_cycle();

        // two contended bursts, each ending in a gap
        burst_alu_first();
        burst_alu_first();
        idle_cycle();

        // same-address collision: MEM wins, both consumed
        cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b1, 1'b1, wr(1'b1, 5'd7, 32'd2));
        chk("collide_cnt", {16'd0, collide_cnt}, 32'd1);
        cycle(1'b1, 5'd5, ALU_D, 1'b1, 5'd6, MEM_D, 1'b1, 1'b0, wr(1'b1, 5'd5, ALU_D));
        idle_cycle();
        chk("collide_cnt_hold", {16'd0, collide_cnt}, 32'd1);

        // write to r0 is consumed and dropped
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b1, wr(1'b0, 5'd0, 32'd0));
        chk("drop_cnt", {16'd0, drop_cnt}, 32'd1);
        idle_cycle();

        // reset mid-burst after two grants (rr_ptr now points at MEM)
        cycle(1'b1, 5'd5, ALU_D, 1'b1, 5'd6, MEM_D, 1'b0, 1'b1, wr(1'b1, 5'd6, MEM_D));
        cycle(1'b1, 5'd5, ALU_D, 1'b1, 5'd6, MEM_D, 1'b1, 1'b0, wr(1'b1, 5'd5, ALU_D));
        Reset = 1'b1;
        #1;
        chk("mid_rst_Write_Reg", {31'd0, Write_Reg}, 32'd0);
        chk("mid_rst_W_Addr", {27'd0, W_Addr}, 32'd0);
        chk("mid_rst_W_Data", W_Data, 32'd0);
        chk("mid_rst_collide", {16'd0, collide_cnt}, 32'd0);
        chk("mid_rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        exp_q.delete();
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("post_rst_state", {30'd0, dbg_state}, 32'd0);
        burst_alu_first();
        idle_cycle();

        // bypass lookup during a write cycle
        R_Addr_A = 5'd9; R_Addr_B = 5'd4;
        cycle(1'b1, 5'd9, 32'hABCD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, wr(1'b1, 5'd9, 32'hABCD));
`ifdef REGFILE_ARB_BYPASS_EN
        chk("fwd_hit_a", {31'd0, fwd_hit_a}, 32'd1);
        chk("fwd_data_a", fwd_data_a, 32'hABCD);
        chk("fwd_hit_b", {31'd0, fwd_hit_b}, 32'd0);
        chk("fwd_data_b", fwd_data_b, 32'd0);
`else
        chk("fwd_hit_a", {31'd0, fwd_hit_a}, 32'd0);
        chk("fwd_hit_b", {31'd0, fwd_hit_b}, 32'd0);
        chk("fwd_data_a", fwd_data_a, 32'd0);
`endif
        idle_cycle();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
